// File: rtl/led_duty_sequencer.sv
// led_duty_sequencer
//   Generates six 16-bit LED duty words for a PWM stage. It steps through four
//   lighting patterns (breathing, chase, blink, off). A debounced push-button
//   selects the pattern. A free-running divider sets how often the pattern
//   advances.
//
// Parameters
//   TICK_DIV  clk cycles per pattern update tick (>= 2)
//   STEP      breathing increment per tick (1..32767)
//   DEBOUNCE  consecutive stable cycles needed to accept a button change (>= 1)
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   btn_n       mode button, active-low, asynchronous to clk
//   duty_flat   six duty words, channel i at [16i+15:16i]
//   duty_valid  one-cycle pulse in the cycle new duty values first appear
//   mode        current pattern: 0 BREATH, 1 CHASE, 2 BLINK, 3 OFF
module led_duty_sequencer #(
  parameter int TICK_DIV = 500000,
  parameter int STEP     = 200,
  parameter int DEBOUNCE = 270000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_n,
  output logic [95:0] duty_flat,
  output logic        duty_valid,
  output logic [1:0]  mode
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);
  localparam logic [15:0]   STEP16    = 16'(STEP);
  localparam logic [15:0]   UP_LIMIT  = 16'(65535 - STEP);
  localparam logic [15:0]   FULL      = 16'hFFFF;

  localparam logic [5:0][15:0] BREATH_INIT = {16'd50000, 16'd40000, 16'd30000,
                                              16'd20000, 16'd10000, 16'd0};

  typedef enum logic [1:0] {
    MODE_BREATH = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_OFF    = 2'd3
  } mode_t;

  mode_t            state_q, state_d;
  logic             sync_a, sync_b;
  logic             db_level;
  logic [DW-1:0]    db_cnt;
  logic             press;
  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [5:0][15:0] duty_q, duty_d;
  logic [5:0]       dir_q, dir_d;
  logic [2:0]       chase_q, chase_d;
  logic [2:0]       blink_cnt_q, blink_cnt_d;
  logic             blink_on_q, blink_on_d;
  logic             valid_q, valid_d;

  // Button conditioning. The debounced level follows the synchronized level
  // only after DEBOUNCE consecutive cycles of disagreement. Accepting a new
  // low level raises a registered one-cycle press pulse. The pattern logic
  // therefore reacts one cycle after the debounced level falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a   <= 1'b1;
      sync_b   <= 1'b1;
      db_level <= 1'b1;
      db_cnt   <= '0;
      press    <= 1'b0;
    end else begin
      sync_a <= btn_n;
      sync_b <= sync_a;
      press  <= 1'b0;
      if (sync_b == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= sync_b;
        db_cnt   <= '0;
        press    <= ~sync_b;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // A press restarts the tick period so the new pattern gets a full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (press || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MODE_BREATH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (press) begin
      case (state_q)
        MODE_BREATH: state_d = MODE_CHASE;
        MODE_CHASE:  state_d = MODE_BLINK;
        MODE_BLINK:  state_d = MODE_OFF;
        default:     state_d = MODE_BREATH;
      endcase
    end
  end

  // Pattern datapath. A press loads the initial pattern of the mode being
  // entered and swallows any coincident tick. A tick advances the current
  // pattern. Both produce a duty_valid pulse.
  always_comb begin
    duty_d      = duty_q;
    dir_d       = dir_q;
    chase_d     = chase_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    valid_d     = 1'b0;
    if (press) begin
      valid_d = 1'b1;
      case (state_d)
        MODE_BREATH: begin
          duty_d = BREATH_INIT;
          dir_d  = '0;
        end
        MODE_CHASE: begin
          chase_d = 3'd0;
          for (int i = 0; i < 6; i++) begin
            duty_d[i] = (i == 0) ? FULL : 16'd0;
          end
        end
        MODE_BLINK: begin
          blink_cnt_d = 3'd0;
          blink_on_d  = 1'b1;
          for (int i = 0; i < 6; i++) begin
            duty_d[i] = FULL;
          end
        end
        default: begin
          duty_d = '0;
        end
      endcase
    end else if (tick) begin
      valid_d = 1'b1;
      case (state_q)
        MODE_BREATH: begin
          // The saturation tests are made before the add or subtract,
          // so the 16-bit result can never wrap.
          for (int i = 0; i < 6; i++) begin
            if (!dir_q[i]) begin
              if (duty_q[i] > UP_LIMIT) begin
                duty_d[i] = FULL;
                dir_d[i]  = 1'b1;
              end else begin
                duty_d[i] = duty_q[i] + STEP16;
              end
            end else begin
              if (duty_q[i] < STEP16) begin
                duty_d[i] = 16'd0;
                dir_d[i]  = 1'b0;
              end else begin
                duty_d[i] = duty_q[i] - STEP16;
              end
            end
          end
        end
        MODE_CHASE: begin
          chase_d = (chase_q == 3'd5) ? 3'd0 : chase_q + 3'd1;
          for (int i = 0; i < 6; i++) begin
            duty_d[i] = (chase_d == 3'(i)) ? FULL : 16'd0;
          end
        end
        MODE_BLINK: begin
          blink_cnt_d = blink_cnt_q + 3'd1;
          if (blink_cnt_q == 3'd7) begin
            blink_on_d = ~blink_on_q;
            for (int i = 0; i < 6; i++) begin
              duty_d[i] = blink_on_q ? 16'd0 : FULL;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q      <= BREATH_INIT;
      dir_q       <= '0;
      chase_q     <= 3'd0;
      blink_cnt_q <= 3'd0;
      blink_on_q  <= 1'b1;
      valid_q     <= 1'b0;
    end else begin
      duty_q      <= duty_d;
      dir_q       <= dir_d;
      chase_q     <= chase_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      valid_q     <= valid_d;
    end
  end

  assign duty_flat  = duty_q;
  assign duty_valid = valid_q;
  assign mode       = state_q;

endmodule

// File: tb/tb_led_duty_sequencer.sv
// tb_led_duty_sequencer
//   Scoreboard bench for led_duty_sequencer with TICK_DIV=4, STEP=20000 and
//   DEBOUNCE=3. Stimulus is applied one cycle at a time. For each cycle, a
//   small pattern model predicts whether the coming edge produces an update.
//   When it does, the expected mode, duties and cycle number are queued.
//   A monitor pops an entry on every duty_valid pulse. Between pulses the
//   monitor checks that the outputs hold their last expected values.
module tb_led_duty_sequencer;

  localparam int TICK_DIV = 4;
  localparam int STEP     = 20000;
  localparam int DEBOUNCE = 3;

  localparam logic [95:0] BREATH_INIT = {16'd50000, 16'd40000, 16'd30000,
                                         16'd20000, 16'd10000, 16'd0};

  logic        clk;
  logic        rst;
  logic        btn_n;
  logic [95:0] duty_flat;
  logic        duty_valid;
  logic [1:0]  mode;

  typedef struct {
    int          cyc;
    logic [1:0]  mode;
    logic [95:0] duty;
  } sbEntry_t;

  sbEntry_t    sbQueue[$];
  sbEntry_t    popped;
  int          checkCount;
  int          failCount;
  int          monCycle;
  logic [1:0]  visMode;
  logic [95:0] visDuty;

  int          mDuty[6];
  bit          mDir[6];
  logic [1:0]  mMode;
  int          mChase;
  int          mBlinkCnt;
  bit          mBlinkOn;
  int          mTick;

  led_duty_sequencer #(
    .TICK_DIV(TICK_DIV),
    .STEP(STEP),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_n(btn_n),
    .duty_flat(duty_flat),
    .duty_valid(duty_valid),
    .mode(mode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [95:0] observed,
                             input logic [95:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [95:0] packModel();
    logic [95:0] packed_duty;
    packed_duty = '0;
    for (int i = 0; i < 6; i++) begin
      packed_duty[16*i +: 16] = 16'(mDuty[i]);
    end
    return packed_duty;
  endfunction

  function automatic void modelLoad(input logic [1:0] newMode);
    mMode = newMode;
    for (int i = 0; i < 6; i++) begin
      case (newMode)
        2'd0: begin
          mDuty[i] = 10000 * i;
          mDir[i]  = 1'b0;
        end
        2'd1: mDuty[i] = (i == 0) ? 65535 : 0;
        2'd2: mDuty[i] = 65535;
        default: mDuty[i] = 0;
      endcase
    end
    mChase    = 0;
    mBlinkCnt = 0;
    mBlinkOn  = 1'b1;
  endfunction

  function automatic void modelTick();
    case (mMode)
      2'd0: begin
        for (int i = 0; i < 6; i++) begin
          if (!mDir[i]) begin
            if (mDuty[i] + STEP > 65535) begin
              mDuty[i] = 65535;
              mDir[i]  = 1'b1;
            end else begin
              mDuty[i] = mDuty[i] + STEP;
            end
          end else begin
            if (mDuty[i] < STEP) begin
              mDuty[i] = 0;
              mDir[i]  = 1'b0;
            end else begin
              mDuty[i] = mDuty[i] - STEP;
            end
          end
        end
      end
      2'd1: begin
        mChase = (mChase + 1) % 6;
        for (int i = 0; i < 6; i++) begin
          mDuty[i] = (i == mChase) ? 65535 : 0;
        end
      end
      2'd2: begin
        if (mBlinkCnt == 7) begin
          mBlinkCnt = 0;
          mBlinkOn  = !mBlinkOn;
          for (int i = 0; i < 6; i++) begin
            mDuty[i] = mBlinkOn ? 65535 : 0;
          end
        end else begin
          mBlinkCnt++;
        end
      end
      default: begin
      end
    endcase
  endfunction

  function automatic void pushExpected();
    sbEntry_t e;
    e.cyc  = monCycle + 1;
    e.mode = mMode;
    e.duty = packModel();
    sbQueue.push_back(e);
  endfunction

  // Called just after a falling edge. It drives btn_n and predicts the next
  // rising edge, then returns at the following falling edge.
  task automatic applyStimulus(input logic btnLevel, input bit pressNow);
    btn_n = btnLevel;
    if (pressNow) begin
      modelLoad(2'(mMode + 2'd1));
      mTick = 0;
      pushExpected();
    end else if (mTick == TICK_DIV - 1) begin
      modelTick();
      mTick = 0;
      pushExpected();
    end else begin
      mTick++;
    end
    @(negedge clk);
  endtask

  // The press takes effect on the sixth edge after btn_n falls: two
  // synchronizer stages, DEBOUNCE stable cycles, then one registered press cycle.
  task automatic pressButton();
    repeat (5) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    repeat (6) applyStimulus(1'b1, 1'b0);
  endtask

  task automatic applyReset(input int holdCycles);
    checkOutput("sb_drain", 96'(sbQueue.size()), 96'd0);
    rst = 1'b1;
    modelLoad(2'd0);
    mTick = 0;
    repeat (holdCycles) @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    monCycle++;
    if (rst) begin
      checkOutput("rst_mode", 96'(mode), 96'd0);
      checkOutput("rst_duty", duty_flat, BREATH_INIT);
      checkOutput("rst_valid", 96'(duty_valid), 96'd0);
      visMode = 2'd0;
      visDuty = BREATH_INIT;
    end else if (duty_valid) begin
      if (sbQueue.size() == 0) begin
        checkOutput("sb_underflow", 96'(duty_valid), 96'd0);
      end else begin
        popped = sbQueue.pop_front();
        checkOutput("sb_cycle", 96'(monCycle), 96'(popped.cyc));
        checkOutput("sb_mode", 96'(mode), 96'(popped.mode));
        checkOutput("sb_duty", duty_flat, popped.duty);
        visMode = popped.mode;
        visDuty = popped.duty;
      end
    end else begin
      checkOutput("hold_mode", 96'(mode), 96'(visMode));
      checkOutput("hold_duty", duty_flat, visDuty);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected completion before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    btn_n      = 1'b1;
    checkCount = 0;
    failCount  = 0;
    monCycle   = 0;
    visMode    = 2'd0;
    visDuty    = BREATH_INIT;
    modelLoad(2'd0);
    mTick = 0;
    @(negedge clk);
    applyReset(3);

    $display("[TB] breathing from reset");
    repeat (22) applyStimulus(1'b1, 1'b0);

    $display("[TB] bounce rejection and mode walk");
    applyReset(2);
    repeat (3) begin
      repeat (2) applyStimulus(1'b0, 1'b0);
      repeat (2) applyStimulus(1'b1, 1'b0);
    end
    repeat (4) applyStimulus(1'b1, 1'b0);
    pressButton();
    repeat (24) applyStimulus(1'b1, 1'b0);
    pressButton();
    repeat (40) applyStimulus(1'b1, 1'b0);
    pressButton();
    repeat (8) applyStimulus(1'b1, 1'b0);
    pressButton();
    repeat (6) applyStimulus(1'b1, 1'b0);

    $display("[TB] press coinciding with tick");
    for (int k = 0; k < 8 && mTick != 2; k++) begin
      applyStimulus(1'b1, 1'b0);
    end
    pressButton();
    repeat (6) applyStimulus(1'b1, 1'b0);

    $display("[TB] reset during debounce in blink");
    pressButton();
    repeat (4) applyStimulus(1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0);
    applyReset(1);
    repeat (2) applyStimulus(1'b0, 1'b0);
    repeat (14) applyStimulus(1'b1, 1'b0);

    checkOutput("sb_drain_end", 96'(sbQueue.size()), 96'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
